// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule stage.
// Provides word/index widths, the schedule FSM state type and the
// small-sigma functions used to expand the 16-word window.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned WIN_LEN = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand
  } sched_state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_adder.sv
// Combinational expansion of one schedule word:
//   W_t = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]  (mod 2^32)
// Ports:
//   w_m2_i, w_m7_i, w_m15_i, w_m16_i : window taps W[t-2], W[t-7], W[t-15], W[t-16]
//   w_t_o                            : expanded word W_t
module sha256_sched_adder
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_m2_i,
  input  logic [WORD_W-1:0] w_m7_i,
  input  logic [WORD_W-1:0] w_m15_i,
  input  logic [WORD_W-1:0] w_m16_i,
  output logic [WORD_W-1:0] w_t_o
);

  logic [WORD_W-1:0] op_a, op_b, op_c, op_d;
  logic [WORD_W-1:0] sum1, car1, sum2, car2;

  // 4:2 reduction as two 3:2 layers, then a single carry-propagate add.
  // The left shifts drop the carry out of bit 31, giving the mod 2^32 result.
  always_comb begin
    op_a  = sigma1(w_m2_i);
    op_b  = w_m7_i;
    op_c  = sigma0(w_m15_i);
    op_d  = w_m16_i;
    sum1  = op_a ^ op_b ^ op_c;
    car1  = ((op_a & op_b) | (op_a & op_c) | (op_b & op_c)) << 1;
    sum2  = sum1 ^ car1 ^ op_d;
    car2  = ((sum1 & car1) | (sum1 & op_d) | (car1 & op_d)) << 1;
    w_t_o = sum2 + car2;
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes a 512-bit block as 16 words over a
// valid/ready stream and emits W0..W[ROUNDS-1], one word per cycle.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begins a block when idle
//   in_valid/in_ready    : message-word handshake, in_word carries W0..W15
//   out_valid/out_ready  : schedule-word handshake, out_word = W_t, out_idx = t
//   busy                 : block in progress
//   done                 : one-cycle pulse after the last word is accepted
// ROUNDS must lie in 16..64.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  // t runs one past the last index so "all words generated" is t == TEnd.
  localparam logic [IDX_W:0] TEnd      = (IDX_W + 1)'(ROUNDS);
  localparam logic [IDX_W:0] TLastLoad = (IDX_W + 1)'(WIN_LEN - 1);

  sched_state_e      state_q;
  logic [IDX_W:0]    t_q;
  logic [WORD_W-1:0] win_q [WIN_LEN];
  logic              out_valid_q;
  logic [WORD_W-1:0] out_word_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic              done_q;

  logic              out_free;
  logic              load_hs;
  logic              gen;
  logic              final_hs;
  logic              push;
  logic [WORD_W-1:0] exp_word;
  logic [WORD_W-1:0] push_word;

  // win_q[15] holds W[t-1], so W[t-k] sits at index 16-k.
  sha256_sched_adder u_adder (
    .w_m2_i  (win_q[14]),
    .w_m7_i  (win_q[9]),
    .w_m15_i (win_q[1]),
    .w_m16_i (win_q[0]),
    .w_t_o   (exp_word)
  );

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = (state_q == StLoad) && out_free;
    load_hs   = in_valid && in_ready;
    gen       = (state_q == StExpand) && out_free && (t_q != TEnd);
    final_hs  = (state_q == StExpand) && (t_q == TEnd) && out_valid_q && out_ready;
    push      = load_hs || gen;
    push_word = load_hs ? in_word : exp_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A new word enters both the output register and the window.
      if (push) begin
        out_valid_q <= 1'b1;
        out_word_q  <= push_word;
        out_idx_q   <= t_q[IDX_W-1:0];
        t_q         <= t_q + 1'b1;
        for (int i = 0; i < WIN_LEN - 1; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[WIN_LEN-1] <= push_word;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            t_q     <= '0;
          end
        end
        StLoad: begin
          if (load_hs && (t_q == TLastLoad)) begin
            state_q <= StExpand;
          end
        end
        StExpand: begin
          if (final_hs) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: a ROUNDS=64 and a ROUNDS=16
// instance share the input stream; words are checked against a small
// reference schedule plus hand-known "abc" constants.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start16;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;

  logic        in_ready, out_valid, busy, done;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        in_ready16, out_valid16, busy16, done16;
  logic [31:0] out_word16;
  logic [5:0]  out_idx16;

  int          n_cmp, n_bad;
  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap   [64];

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start16),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .in_word   (in_word),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .out_word  (out_word16),
    .out_idx   (out_idx16),
    .busy      (busy16),
    .done      (done16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic build_exp();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
  endtask

  // exact: no stalls, so the block-time is checked too.
  // poke_at: pulse start once when that many words have been accepted.
  // rst_at: assert reset while that out_idx is on the output.
  task automatic run_block(input int rdy_pct, input int gap_pct, input int poke_at,
                           input int rst_at);
    int   cyc, in_pos, got, got16, last_hs, last_hs16;
    bit   d64, d16, held_v, stop, poked, exact;
    logic [38:0] held;
    build_exp();
    for (int i = 0; i < 64; i++) cap[i] = 32'hxxxx_xxxx;
    exact = (rdy_pct >= 100) && (gap_pct == 0);
    cyc = 0; in_pos = 0; got = 0; got16 = 0; last_hs = -10; last_hs16 = -10;
    d64 = 0; d16 = 0; held_v = 0; stop = 0; poked = 0; held = '0;
    @(negedge clk);
    start = 1'b1;
    start16 = 1'b1;
    while (!stop) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = (in_pos < 16) && ($urandom_range(99) >= gap_pct);
      in_word   = (in_pos < 16) ? blk[in_pos] : 32'hdead_beef;
      if (poke_at >= 0 && !poked && got == poke_at) begin
        start = 1'b1;
        poked = 1'b1;
      end
      #1;
      if (in_valid && in_ready) in_pos++;
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (got < 64) begin
          check_eq("w64", {6'(got), exp_w[got]}, {out_idx, out_word});
          cap[got] = out_word;
        end else begin
          check_eq("w64_extra", got, 64);
        end
        got++;
        last_hs = cyc;
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {1'b1, out_idx, out_word};
      end
      if (out_valid16 && out_ready) begin
        if (got16 < 16) check_eq("w16", {6'(got16), exp_w[got16]}, {out_idx16, out_word16});
        else check_eq("w16_extra", got16, 16);
        got16++;
        last_hs16 = cyc;
      end

      @(negedge clk);
      cyc++;
      start   = 1'b0;
      start16 = 1'b0;
      if (cyc == 1) check_eq("busy_after_start", {busy, busy16}, 2'b11);
      if (held_v) check_eq("hold", {out_valid, out_idx, out_word}, held);
      if (done) begin
        check_eq("done_once", d64, 0);
        d64 = 1'b1;
        check_eq("done_lat", cyc, last_hs + 1);
        check_eq("done_count", got, 64);
        check_eq("idle_after_done", busy, 0);
        if (exact) check_eq("block_cycles", cyc, 66);
      end
      if (done16) begin
        check_eq("done16_once", d16, 0);
        d16 = 1'b1;
        check_eq("done16_lat", cyc, last_hs16 + 1);
        check_eq("done16_count", got16, 16);
        check_eq("idle16_after_done", busy16, 0);
      end
      if (rst_at >= 0 && out_valid && out_idx == 6'(rst_at)) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {in_ready, out_valid, busy, done, out_idx, out_word}, 0);
        @(negedge clk);
        check_eq("rst_hold", {in_ready, out_valid, busy, done, out_idx, out_word}, 0);
        rst_n = 1'b1;
        stop  = 1'b1;
      end
      if (d64 && d16) stop = 1'b1;
      if (cyc > 3000) begin
        check_eq("timeout", {d64, d16}, 2'b11);
        stop = 1'b1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("stays_idle", {busy, busy16, out_valid, out_valid16}, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset64", {in_ready, out_valid, busy, done, out_idx, out_word}, 0);
    check_eq("reset16", {in_ready16, out_valid16, busy16, done16, out_idx16, out_word16}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_no_start", {in_ready, busy, out_valid}, 0);

    // "abc" block, no stalls, hand-known words.
    set_abc();
    run_block(100, 0, -1, -1);
    check_eq("abc_w0",  cap[0],  32'h6162_6380);
    check_eq("abc_w15", cap[15], 32'h0000_0018);
    check_eq("abc_w16", cap[16], 32'h6162_6380);
    check_eq("abc_w17", cap[17], 32'h000F_0000);
    check_eq("abc_w18", cap[18], 32'h7DA8_6405);
    check_eq("abc_w63", cap[63], 32'h12B1_EDEB);

    // All-zero block.
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    run_block(100, 0, -1, -1);
    check_eq("zero_w40", cap[40], 32'h0);

    // Backpressure, then input gaps, then both.
    set_abc();
    run_block(50, 0, -1, -1);
    check_eq("bp_w63", cap[63], 32'h12B1_EDEB);
    run_block(100, 40, -1, -1);
    check_eq("gap_w18", cap[18], 32'h7DA8_6405);

    for (int i = 0; i < 16; i++) blk[i] = 32'h0101_0101 * (i + 1) ^ 32'h8000_0003;
    run_block(60, 30, -1, -1);

    // start during EXPAND, then reset at idx 30, then a fresh block.
    set_abc();
    run_block(100, 0, 30, -1);
    run_block(100, 0, -1, 30);
    run_block(100, 0, -1, -1);
    check_eq("after_rst_w0", cap[0], 32'h6162_6380);
    check_eq("after_rst_w63", cap[63], 32'h12B1_EDEB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
